// File: rtl/lut_table_loader.sv
// Runtime-loadable truth-table neuron: streams a DEPTH-entry table into
// distributed RAM, then answers registered lookups of IN_BITS input codes.
module lut_table_loader #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [OUT_BITS-1:0] cfg_data,
    input  logic                cfg_last,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data,
    output logic                loaded,
    output logic                err
);

    localparam int DEPTH = 2 ** IN_BITS;
    localparam logic [IN_BITS-1:0] LAST_ADDR = IN_BITS'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ACTIVE
    } state_t;

    state_t                state_reg;
    logic [IN_BITS-1:0]    wr_addr_reg;
    logic                  cfg_ready_reg;
    logic                  err_reg;
    logic                  out_valid_reg;
    logic [OUT_BITS-1:0]   out_data_reg;
    logic [OUT_BITS-1:0]   table_mem [DEPTH];

    logic beat;
    logic lookup;

    assign beat   = cfg_valid && cfg_ready_reg;
    assign lookup = in_valid && (state_reg == ACTIVE);

    // Table storage is deliberately not reset; a stale table is never
    // readable because lookups are only accepted in ACTIVE.
    always_ff @(posedge clk) begin
        if (beat) begin
            table_mem[wr_addr_reg] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            wr_addr_reg   <= '0;
            cfg_ready_reg <= 1'b0;
            err_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            cfg_ready_reg <= 1'b1;
            out_valid_reg <= lookup;
            // Non-blocking read returns the entry as it was before any
            // write landing on the same edge.
            if (lookup) begin
                out_data_reg <= table_mem[in_data];
            end

            // Framing is independent of the current state: any accepted beat
            // either continues a frame, completes it, or aborts it.
            if (beat) begin
                if (cfg_last && wr_addr_reg == LAST_ADDR) begin
                    state_reg   <= ACTIVE;
                    err_reg     <= 1'b0;
                    wr_addr_reg <= '0;
                end else if (cfg_last || wr_addr_reg == LAST_ADDR) begin
                    state_reg   <= IDLE;
                    err_reg     <= 1'b1;
                    wr_addr_reg <= '0;
                end else begin
                    state_reg   <= LOAD;
                    wr_addr_reg <= wr_addr_reg + 1'b1;
                end
            end
        end
    end

    assign cfg_ready = cfg_ready_reg;
    assign in_ready  = (state_reg == ACTIVE);
    assign loaded    = (state_reg == ACTIVE);
    assign err       = err_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

endmodule

// File: tb/tb_lut_table_loader.sv
// Directed + randomized bench for lut_table_loader, checked every cycle
// against a table/flag reference model derived from the framing rules.
module tb_lut_table_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_data = '0;
    logic       cfg_last = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] in_data = '0;
    logic       out_valid;
    logic [1:0] out_data;
    logic       loaded;
    logic       err;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [1:0] ref_table [64];
    int         ref_pos = 0;
    bit         ref_loaded = 0;
    bit         ref_err = 0;
    bit         ref_cfg_ready = 0;
    bit         ref_ov = 0;
    logic [1:0] ref_out = '0;

    lut_table_loader #(.IN_BITS(6), .OUT_BITS(2)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_data(cfg_data), .cfg_last(cfg_last),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data),
        .loaded(loaded), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance the model across the edge,
    // then compare every output 1 time unit after the edge.
    task automatic cycle(input logic cv, input logic [1:0] cd, input logic cl,
                         input logic iv, input logic [5:0] id);
        bit acc;
        cfg_valid = cv; cfg_data = cd; cfg_last = cl;
        in_valid = iv;  in_data = id;
        @(posedge clk);
        acc = 0;
        if (!rst) begin
            ref_pos = 0; ref_loaded = 0; ref_err = 0;
            ref_cfg_ready = 0; ref_ov = 0; ref_out = '0;
        end else begin
            acc = iv && ref_loaded;
            ref_ov = acc;
            if (acc) ref_out = ref_table[id];
            if (cv && ref_cfg_ready) begin
                ref_table[ref_pos] = cd;
                if (cl) begin
                    ref_loaded = (ref_pos == 63);
                    ref_err    = (ref_pos != 63);
                    ref_pos    = 0;
                end else if (ref_pos == 63) begin
                    ref_loaded = 0; ref_err = 1; ref_pos = 0;
                end else begin
                    ref_loaded = 0; ref_pos = ref_pos + 1;
                end
            end
            ref_cfg_ready = 1;
        end
        #1;
        chk("cfg_ready", {7'd0, cfg_ready}, {7'd0, ref_cfg_ready});
        chk("in_ready",  {7'd0, in_ready},  {7'd0, ref_loaded});
        chk("loaded",    {7'd0, loaded},    {7'd0, ref_loaded});
        chk("err",       {7'd0, err},       {7'd0, ref_err});
        chk("out_valid", {7'd0, out_valid}, {7'd0, ref_ov});
        chk("out_data",  {6'd0, out_data},  {6'd0, ref_out});
        if (acc) $display("[TB] lookup %0d -> %0d (expected %0d)", id, out_data, ref_out);
    endtask

    // kind 0: a[1:0], kind 1: ~a[1:0], otherwise random data
    task automatic send_frame(input int first, input int n, input int last_idx,
                              input int kind, input bit gaps);
        for (int i = first; i < n; i++) begin
            logic [5:0] a;
            logic [1:0] d;
            a = i[5:0];
            if (kind == 0)      d = a[1:0];
            else if (kind == 1) d = ~a[1:0];
            else                d = 2'($urandom_range(0, 3));
            if (gaps && $urandom_range(0, 3) == 0) cycle(0, 2'd0, 0, 0, 6'd0);
            cycle(1, d, (i == last_idx), 0, 6'd0);
        end
        $display("[TB] frame beats %0d..%0d sent, loaded=%0d err=%0d", first, n - 1, loaded, err);
    endtask

    task automatic rand_lookups(input int n);
        for (int i = 0; i < n; i++)
            cycle(0, 2'd0, 0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
    endtask

    initial begin
        // Reset state, with a stray beat offered during reset
        rst = 0;
        cycle(0, 2'd0, 0, 0, 6'd0);
        cycle(1, 2'd3, 1, 1, 6'd5);
        chk("rst_out_data", {6'd0, out_data}, 8'd0);
        rst = 1;
        cycle(0, 2'd0, 0, 0, 6'd0);

        // Full load of a[1:0], then the directed lookup of 6'b101101
        send_frame(0, 64, 63, 0, 0);
        chk("load_loaded", {7'd0, loaded}, 8'd1);
        cycle(0, 2'd0, 0, 1, 6'b101101);
        chk("lookup_45", {6'd0, out_data}, 8'd1);

        // Back-to-back lookups 0..63 then idle: hold check
        for (int i = 0; i < 64; i++) cycle(0, 2'd0, 0, 1, 6'(i));
        cycle(0, 2'd0, 0, 0, 6'd0);
        chk("hold_out_data", {6'd0, out_data}, 8'd3);
        rand_lookups(40);

        // Short frame (last on beat 10), then a full random load with gaps
        send_frame(0, 11, 10, 2, 0);
        chk("short_err", {7'd0, err}, 8'd1);
        rand_lookups(5);
        send_frame(0, 64, 63, 2, 1);
        chk("recover_err", {7'd0, err}, 8'd0);
        rand_lookups(60);

        // Long frame: 64 beats without last, beat 65 lands at address 0
        send_frame(0, 64, -1, 2, 0);
        chk("long_err", {7'd0, err}, 8'd1);
        cycle(1, 2'b10, 0, 0, 6'd0);
        send_frame(1, 64, 63, 2, 0);
        cycle(0, 2'd0, 0, 1, 6'd0);
        chk("long_beat65", {6'd0, out_data}, 8'd2);

        // Reload while ACTIVE with same-cycle lookup of entry 0
        send_frame(0, 64, 63, 0, 0);
        cycle(1, 2'b11, 0, 1, 6'd0);
        chk("reload_old0", {6'd0, out_data}, 8'd0);
        chk("reload_ready", {7'd0, in_ready}, 8'd0);
        send_frame(1, 64, 63, 1, 0);
        cycle(0, 2'd0, 0, 1, 6'd0);
        chk("reload_new0", {6'd0, out_data}, 8'd3);
        rand_lookups(30);

        // Reset in the middle of a frame, then a fresh load
        send_frame(0, 30, -1, 2, 0);
        rst = 0;
        cycle(1, 2'd1, 0, 1, 6'd9);
        chk("midrst_ready", {7'd0, cfg_ready}, 8'd0);
        rst = 1;
        cycle(0, 2'd0, 0, 0, 6'd0);
        send_frame(0, 64, 63, 2, 1);
        chk("fresh_loaded", {7'd0, loaded}, 8'd1);
        rand_lookups(60);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
